// File: rtl/ad1xx_memctl.sv
// ad1xx_memctl: dual-port RAM/ROM controller with registered req/ack per port.
// Latency: ack in the cycle 1+WAIT_STATES after the req edge; +1 for port 2 per ROM arbitration loss.
// Backpressure: none; requesters hold req until ack, req is ignored while a port is waiting.
//
// Ports: clk, rst_n (sync, active-low)
//        p1_req/p1_addr -> p1_ack/p1_err/p1_rdata   instruction fetch, read-only
//        p2_req/p2_addr/p2_be/p2_wdata -> p2_ack/p2_err/p2_rdata   load/store
//        rom_addr -> rom_data   combinational boot ROM, shared by both ports
module ad1xx_memctl #(
    // Window bases are in units of the window size: addr[29:AW] is compared against them.
    parameter logic [29:0] RAM_BASE    = 30'h3800,
    parameter int          RAM_AW      = 13,
    parameter logic [29:0] ROM_BASE    = 30'hFF000,
    parameter int          ROM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter bit          P2_ROM_READ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p1_req,
    input  logic [29:0]       p1_addr,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [31:0]       p1_rdata,
    input  logic              p2_req,
    input  logic [29:0]       p2_addr,
    input  logic [3:0]        p2_be,
    input  logic [31:0]       p2_wdata,
    output logic              p2_ack,
    output logic              p2_err,
    output logic [31:0]       p2_rdata,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data
);

    localparam int       RAM_WORDS = 1 << RAM_AW;
    localparam bit       ZERO_WAIT = (WAIT_STATES == 0);
    // The counter holds the number of WAIT edges still to pass before the
    // capture edge, so a request with N wait states loads N-1.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      p1_st, p1_st_nxt, p2_st, p2_st_nxt;
    logic [3:0]  p1_cnt, p1_cnt_nxt, p2_cnt, p2_cnt_nxt;
    logic [29:0] p1_addr_q, p2_addr_q;
    logic [3:0]  p2_be_q;
    logic [31:0] p2_wdata_q;
    logic [31:0] mem [RAM_WORDS];

    // Effective transaction at this edge: live inputs when starting from
    // IDLE/RESP (zero-wait capture), latched copies while in WAIT.
    logic        p1_start, p2_start, p1_try, p2_try, p1_cap, p2_cap, p2_blk;
    logic [29:0] p1_a, p2_a;
    logic [3:0]  p2_be_e;
    logic [31:0] p2_wd_e;
    logic        p1_ram, p1_rom, p2_ram, p2_rom, p2_wr;
    logic        p1_err_c, p2_err_c;
    logic [31:0] p1_rdata_c, p2_rdata_c;

    assign p1_start = p1_req && (p1_st != ST_WAIT);
    assign p2_start = p2_req && (p2_st != ST_WAIT);
    assign p1_try   = (ZERO_WAIT && p1_start) || (p1_st == ST_WAIT && p1_cnt == 4'd0);
    assign p2_try   = (ZERO_WAIT && p2_start) || (p2_st == ST_WAIT && p2_cnt == 4'd0);
    assign p1_a     = (p1_st == ST_WAIT) ? p1_addr_q  : p1_addr;
    assign p2_a     = (p2_st == ST_WAIT) ? p2_addr_q  : p2_addr;
    assign p2_be_e  = (p2_st == ST_WAIT) ? p2_be_q    : p2_be;
    assign p2_wd_e  = (p2_st == ST_WAIT) ? p2_wdata_q : p2_wdata;

    // RAM wins if the two windows were ever configured to overlap.
    assign p1_ram = ((p1_a >> RAM_AW) == RAM_BASE);
    assign p1_rom = ((p1_a >> ROM_AW) == ROM_BASE) && !p1_ram;
    assign p2_ram = ((p2_a >> RAM_AW) == RAM_BASE);
    assign p2_rom = ((p2_a >> ROM_AW) == ROM_BASE) && !p2_ram;
    assign p2_wr  = (p2_be_e != 4'd0);

    // Single ROM read port: port 1 has fixed priority.
    assign p1_cap   = p1_try;
    assign p2_blk   = p1_cap && p1_rom && p2_rom;
    assign p2_cap   = p2_try && !p2_blk;
    assign rom_addr = (p1_cap && p1_rom) ? p1_a[ROM_AW-1:0] : p2_a[ROM_AW-1:0];

    assign p1_err_c   = !(p1_ram || p1_rom);
    assign p1_rdata_c = p1_err_c ? 32'd0 : (p1_ram ? mem[p1_a[RAM_AW-1:0]] : rom_data);
    assign p2_err_c   = !(p2_ram || p2_rom) || (p2_rom && (p2_wr || !P2_ROM_READ));
    assign p2_rdata_c = (p2_err_c || p2_wr) ? 32'd0 :
                        (p2_ram ? mem[p2_a[RAM_AW-1:0]] : rom_data);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_st  <= ST_IDLE;
            p2_st  <= ST_IDLE;
            p1_cnt <= 4'd0;
            p2_cnt <= 4'd0;
        end else begin
            p1_st  <= p1_st_nxt;
            p2_st  <= p2_st_nxt;
            p1_cnt <= p1_cnt_nxt;
            p2_cnt <= p2_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        p1_st_nxt  = p1_st;
        p1_cnt_nxt = p1_cnt;
        case (p1_st)
            ST_IDLE, ST_RESP: begin
                if (!p1_req)     p1_st_nxt = ST_IDLE;
                else if (p1_cap) p1_st_nxt = ST_RESP;
                else begin
                    p1_st_nxt  = ST_WAIT;
                    p1_cnt_nxt = WS_LOAD;
                end
            end
            ST_WAIT: begin
                if (p1_cap)                p1_st_nxt  = ST_RESP;
                else if (p1_cnt != 4'd0)   p1_cnt_nxt = p1_cnt - 4'd1;
            end
            default: p1_st_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        p2_st_nxt  = p2_st;
        p2_cnt_nxt = p2_cnt;
        case (p2_st)
            ST_IDLE, ST_RESP: begin
                if (!p2_req)     p2_st_nxt = ST_IDLE;
                else if (p2_cap) p2_st_nxt = ST_RESP;
                else begin
                    // Also the path for a zero-wait request that lost ROM arbitration.
                    p2_st_nxt  = ST_WAIT;
                    p2_cnt_nxt = WS_LOAD;
                end
            end
            ST_WAIT: begin
                if (p2_cap)                p2_st_nxt  = ST_RESP;
                else if (p2_cnt != 4'd0)   p2_cnt_nxt = p2_cnt - 4'd1;
            end
            default: p2_st_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        p1_ack = (p1_st == ST_RESP);
        p2_ack = (p2_st == ST_RESP);
    end

    // Request latches
    always_ff @(posedge clk) begin
        if (p1_start) p1_addr_q <= p1_addr;
        if (p2_start) begin
            p2_addr_q  <= p2_addr;
            p2_be_q    <= p2_be;
            p2_wdata_q <= p2_wdata;
        end
    end

    // Response data, held until the next capture edge of the same port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_err   <= 1'b0;
            p1_rdata <= 32'd0;
            p2_err   <= 1'b0;
            p2_rdata <= 32'd0;
        end else begin
            if (p1_cap) begin
                p1_err   <= p1_err_c;
                p1_rdata <= p1_rdata_c;
            end
            if (p2_cap) begin
                p2_err   <= p2_err_c;
                p2_rdata <= p2_rdata_c;
            end
        end
    end

    // RAM write port; contents survive reset, but reset blocks a commit.
    // A same-edge port 1 read of this word sees the old value.
    always_ff @(posedge clk) begin
        if (rst_n && p2_cap && p2_ram && p2_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (p2_be_e[b]) mem[p2_a[RAM_AW-1:0]][8*b +: 8] <= p2_wd_e[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ad1xx_memctl.sv
// Self-checking bench for ad1xx_memctl: three instances (WS=0; WS=3; WS=2 with
// port 2 ROM reads disabled), scoreboard of expected responses per transaction.
module tb_ad1xx_memctl;

    localparam logic [29:0] RAMB = 30'h1C00_0000;   // byte 0x7000_0000
    localparam logic [29:0] ROMB = 30'h3FC0_0000;   // byte 0xFF00_0000

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } rsp_t;

    localparam rsp_t NONE = '{port: 2'd0, rdata: 32'd0, err: 1'b0, lat: 8'hFF};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          vec = 0;
    int          miss = 0;
    rsp_t        expq[$];
    rsp_t        obs[$];

    logic        p1_req   [3];
    logic [29:0] p1_addr  [3];
    logic        p1_ack   [3];
    logic        p1_err   [3];
    logic [31:0] p1_rdata [3];
    logic        p2_req   [3];
    logic [29:0] p2_addr  [3];
    logic [3:0]  p2_be    [3];
    logic [31:0] p2_wdata [3];
    logic        p2_ack   [3];
    logic        p2_err   [3];
    logic [31:0] p2_rdata [3];
    logic [9:0]  rom_addr [3];
    logic [31:0] rom_data [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_fn(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a} + 32'h0000_0100;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rom_data[g] = rom_fn(rom_addr[g]);
        ad1xx_memctl #(
            .RAM_BASE    (30'hE000),
            .RAM_AW      (13),
            .ROM_BASE    (30'hFF000),
            .ROM_AW      (10),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2),
            .P2_ROM_READ ((g == 2) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .p1_req   (p1_req[g]),
            .p1_addr  (p1_addr[g]),
            .p1_ack   (p1_ack[g]),
            .p1_err   (p1_err[g]),
            .p1_rdata (p1_rdata[g]),
            .p2_req   (p2_req[g]),
            .p2_addr  (p2_addr[g]),
            .p2_be    (p2_be[g]),
            .p2_wdata (p2_wdata[g]),
            .p2_ack   (p2_ack[g]),
            .p2_err   (p2_err[g]),
            .p2_rdata (p2_rdata[g]),
            .rom_addr (rom_addr[g]),
            .rom_data (rom_data[g])
        );
    end

    function automatic rsp_t mk(input logic [1:0] p, input logic [31:0] d, input logic e, input int l);
        return '{port: p, rdata: d, err: e, lat: 8'(l)};
    endfunction

    // Issue one transaction on either or both ports of an instance, hold req
    // until ack, and record every ack seen (including unexpected ones).
    task automatic drive(input int inst, input logic e1, input logic [29:0] a1,
                         input logic e2, input logic [29:0] a2,
                         input logic [3:0] be, input logic [31:0] wd);
        int   k0;
        logic pend1, pend2;
        @(negedge clk);
        p1_req[inst] = e1;  p1_addr[inst] = a1;
        p2_req[inst] = e2;  p2_addr[inst] = a2;
        p2_be[inst]  = be;  p2_wdata[inst] = wd;
        k0 = cyc;  pend1 = e1;  pend2 = e2;
        for (int n = 0; n < 40 && (pend1 || pend2); n++) begin
            @(negedge clk);
            if (p1_ack[inst]) begin
                obs.push_back(mk(2'd1, p1_rdata[inst], p1_err[inst], cyc - k0));
                p1_req[inst] = 1'b0;  pend1 = 1'b0;
            end
            if (p2_ack[inst]) begin
                obs.push_back(mk(2'd2, p2_rdata[inst], p2_err[inst], cyc - k0));
                p2_req[inst] = 1'b0;  pend2 = 1'b0;
            end
        end
        p1_req[inst] = 1'b0;
        p2_req[inst] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (p1_ack[inst]) obs.push_back(mk(2'd1, p1_rdata[inst], p1_err[inst], cyc - k0));
            if (p2_ack[inst]) obs.push_back(mk(2'd2, p2_rdata[inst], p2_err[inst], cyc - k0));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p1_req[i] = 1'b0;  p1_addr[i] = '0;
            p2_req[i] = 1'b0;  p2_addr[i] = '0;  p2_be[i] = '0;  p2_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vec++;
            if ({p1_ack[i], p2_ack[i], p1_err[i], p2_err[i], p1_rdata[i], p2_rdata[i]} !== 68'd0) begin
                miss++;
                $display("FAIL reset[%0d]: got ack=%b%b err=%b%b rd1=%h rd2=%h, want all zero",
                         i, p1_ack[i], p2_ack[i], p1_err[i], p2_err[i], p1_rdata[i], p2_rdata[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        rsp_t e, o;
        expq.push_back(mk(2'd2, 32'd0, 1'b0, 1));
        drive(0, 1'b0, '0, 1'b1, RAMB + 30'd1, 4'hF, 32'hDEAD_BEEF);
        expq.push_back(mk(2'd2, 32'hDEAD_BEEF, 1'b0, 1));
        drive(0, 1'b0, '0, 1'b1, RAMB + 30'd1, 4'h0, 32'd0);
        expq.push_back(mk(2'd2, 32'd0, 1'b0, 1));
        drive(0, 1'b0, '0, 1'b1, RAMB + 30'd1, 4'b0101, 32'h1122_3344);
        expq.push_back(mk(2'd2, 32'hDE22_BE44, 1'b0, 1));
        drive(0, 1'b0, '0, 1'b1, RAMB + 30'd1, 4'h0, 32'd0);
        while (expq.size() != 0 || obs.size() != 0) begin
            e = NONE;  o = NONE;
            if (expq.size() != 0) e = expq.pop_front();
            if (obs.size() != 0)  o = obs.pop_front();
            vec++;
            if (o !== e) begin
                miss++;
                $display("FAIL write_read: got p%0d rd=%h err=%0d lat=%0d, want p%0d rd=%h err=%0d lat=%0d",
                         o.port, o.rdata, o.err, o.lat, e.port, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_wait_states;
        rsp_t e, o;
        expq.push_back(mk(2'd1, rom_fn(10'd0), 1'b0, 4));
        drive(1, 1'b1, ROMB, 1'b0, '0, 4'h0, 32'd0);
        expq.push_back(mk(2'd2, 32'd0, 1'b0, 4));
        drive(1, 1'b0, '0, 1'b1, RAMB + 30'd5, 4'hF, 32'h5566_7788);
        expq.push_back(mk(2'd2, 32'h5566_7788, 1'b0, 4));
        drive(1, 1'b0, '0, 1'b1, RAMB + 30'd5, 4'h0, 32'd0);
        while (expq.size() != 0 || obs.size() != 0) begin
            e = NONE;  o = NONE;
            if (expq.size() != 0) e = expq.pop_front();
            if (obs.size() != 0)  o = obs.pop_front();
            vec++;
            if (o !== e) begin
                miss++;
                $display("FAIL wait_states: got p%0d rd=%h err=%0d lat=%0d, want p%0d rd=%h err=%0d lat=%0d",
                         o.port, o.rdata, o.err, o.lat, e.port, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_rom_conflict;
        rsp_t e, o;
        expq.push_back(mk(2'd1, rom_fn(10'd5), 1'b0, 1));
        expq.push_back(mk(2'd2, rom_fn(10'd7), 1'b0, 2));
        drive(0, 1'b1, ROMB + 30'd5, 1'b1, ROMB + 30'd7, 4'h0, 32'd0);
        expq.push_back(mk(2'd1, rom_fn(10'd11), 1'b0, 4));
        expq.push_back(mk(2'd2, rom_fn(10'd12), 1'b0, 5));
        drive(1, 1'b1, ROMB + 30'd11, 1'b1, ROMB + 30'd12, 4'h0, 32'd0);
        while (expq.size() != 0 || obs.size() != 0) begin
            e = NONE;  o = NONE;
            if (expq.size() != 0) e = expq.pop_front();
            if (obs.size() != 0)  o = obs.pop_front();
            vec++;
            if (o !== e) begin
                miss++;
                $display("FAIL rom_conflict: got p%0d rd=%h err=%0d lat=%0d, want p%0d rd=%h err=%0d lat=%0d",
                         o.port, o.rdata, o.err, o.lat, e.port, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_errors;
        rsp_t e, o;
        expq.push_back(mk(2'd1, 32'd0, 1'b1, 1));
        expq.push_back(mk(2'd2, 32'd0, 1'b1, 1));
        drive(0, 1'b1, 30'd0, 1'b1, ROMB, 4'hF, 32'h1234_5678);
        expq.push_back(mk(2'd2, rom_fn(10'd9), 1'b0, 1));
        drive(0, 1'b0, '0, 1'b1, ROMB + 30'd9, 4'h0, 32'd0);
        expq.push_back(mk(2'd2, 32'd0, 1'b1, 3));
        drive(2, 1'b0, '0, 1'b1, ROMB + 30'd4, 4'h0, 32'd0);
        expq.push_back(mk(2'd1, rom_fn(10'd4), 1'b0, 3));
        drive(2, 1'b1, ROMB + 30'd4, 1'b0, '0, 4'h0, 32'd0);
        while (expq.size() != 0 || obs.size() != 0) begin
            e = NONE;  o = NONE;
            if (expq.size() != 0) e = expq.pop_front();
            if (obs.size() != 0)  o = obs.pop_front();
            vec++;
            if (o !== e) begin
                miss++;
                $display("FAIL errors: got p%0d rd=%h err=%0d lat=%0d, want p%0d rd=%h err=%0d lat=%0d",
                         o.port, o.rdata, o.err, o.lat, e.port, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_collision;
        rsp_t e, o;
        expq.push_back(mk(2'd2, 32'd0, 1'b0, 1));
        drive(0, 1'b0, '0, 1'b1, RAMB + 30'd2, 4'hF, 32'h1234_5678);
        expq.push_back(mk(2'd1, 32'h1234_5678, 1'b0, 1));
        expq.push_back(mk(2'd2, 32'd0, 1'b0, 1));
        drive(0, 1'b1, RAMB + 30'd2, 1'b1, RAMB + 30'd2, 4'hF, 32'hAAAA_5555);
        expq.push_back(mk(2'd1, 32'hAAAA_5555, 1'b0, 1));
        drive(0, 1'b1, RAMB + 30'd2, 1'b0, '0, 4'h0, 32'd0);
        while (expq.size() != 0 || obs.size() != 0) begin
            e = NONE;  o = NONE;
            if (expq.size() != 0) e = expq.pop_front();
            if (obs.size() != 0)  o = obs.pop_front();
            vec++;
            if (o !== e) begin
                miss++;
                $display("FAIL collision: got p%0d rd=%h err=%0d lat=%0d, want p%0d rd=%h err=%0d lat=%0d",
                         o.port, o.rdata, o.err, o.lat, e.port, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_reset_pending;
        rsp_t e, o;
        expq.push_back(mk(2'd2, 32'd0, 1'b0, 3));
        drive(2, 1'b0, '0, 1'b1, RAMB + 30'd3, 4'hF, 32'h0BAD_F00D);
        // Overwrite attempt, killed by reset held across its capture edge.
        @(negedge clk);
        p2_req[2] = 1'b1;  p2_addr[2] = RAMB + 30'd3;  p2_be[2] = 4'hF;  p2_wdata[2] = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vec++;
            if ({p1_ack[2], p2_ack[2]} !== 2'b00) begin
                miss++;
                $display("FAIL reset_pending ack: got %b%b, want 00", p1_ack[2], p2_ack[2]);
            end
        end
        p2_req[2] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vec++;
        if ({p2_ack[2], p2_err[2], p2_rdata[2]} !== 34'd0) begin
            miss++;
            $display("FAIL reset_pending idle: got ack=%b err=%b rd=%h, want 0 0 0",
                     p2_ack[2], p2_err[2], p2_rdata[2]);
        end
        expq.push_back(mk(2'd2, 32'h0BAD_F00D, 1'b0, 3));
        drive(2, 1'b0, '0, 1'b1, RAMB + 30'd3, 4'h0, 32'd0);
        while (expq.size() != 0 || obs.size() != 0) begin
            e = NONE;  o = NONE;
            if (expq.size() != 0) e = expq.pop_front();
            if (obs.size() != 0)  o = obs.pop_front();
            vec++;
            if (o !== e) begin
                miss++;
                $display("FAIL reset_pending: got p%0d rd=%h err=%0d lat=%0d, want p%0d rd=%h err=%0d lat=%0d",
                         o.port, o.rdata, o.err, o.lat, e.port, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acks;
        // Zero wait states: ack stays high while req is held.
        @(negedge clk);
        p1_req[0] = 1'b1;  p1_addr[0] = ROMB + 30'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++;
            if ({p1_ack[0], p1_err[0], p1_rdata[0]} !== {1'b1, 1'b0, rom_fn(10'd2)}) begin
                miss++;
                $display("FAIL b2b_ws0[%0d]: got ack=%b err=%b rd=%h, want 1 0 %h",
                         i, p1_ack[0], p1_err[0], p1_rdata[0], rom_fn(10'd2));
            end
        end
        p1_req[0] = 1'b0;
        @(negedge clk);
        vec++;
        if (p1_ack[0] !== 1'b0) begin
            miss++;
            $display("FAIL b2b_ws0 drop: got ack=%b, want 0", p1_ack[0]);
        end
        // Three wait states: one ack per four cycles, req during WAIT ignored.
        acks = 0;
        @(negedge clk);
        p1_req[1] = 1'b1;  p1_addr[1] = ROMB + 30'd3;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (p1_ack[1]) acks++;
            if (i == 4) begin
                vec++;
                if ({p1_ack[1], p1_rdata[1]} !== {1'b1, rom_fn(10'd3)}) begin
                    miss++;
                    $display("FAIL b2b_ws3 first: got ack=%b rd=%h, want 1 %h",
                             p1_ack[1], p1_rdata[1], rom_fn(10'd3));
                end
            end
        end
        p1_req[1] = 1'b0;
        @(negedge clk);
        if (p1_ack[1]) acks++;
        vec++;
        if (acks !== 3) begin
            miss++;
            $display("FAIL b2b_ws3 count: got %0d acks, want 3", acks);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_rom_conflict();
        test_errors();
        test_collision();
        test_reset_pending();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
